// File: rtl/prach_pkg.sv
// prach_pkg: shared PRACH sample/tag types, FSM states and dp/dq lane index mapping.
package prach_pkg;

    typedef logic [15:0] sample_t;
    typedef logic [7:0]  chn_t;

    typedef enum logic {W_IDLE, W_FILL}  wr_st_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_st_t;

    // dp format: cycle i carries x[2i], x[2i+1]; dq format: cycle j carries x[j], x[SIZE+j]
    function automatic int dp1_idx(input int i);
        return 2 * i;
    endfunction

    function automatic int dp2_idx(input int i);
        return 2 * i + 1;
    endfunction

    function automatic int dq1_idx(input int j);
        return j;
    endfunction

    function automatic int dq2_idx(input int size, input int j);
        return size + j;
    endfunction

endpackage

// File: rtl/prach_unshape_buf.sv
// prach_unshape_buf: two-bank flop store, dp-order writes and dq-order registered reads.
module prach_unshape_buf
    import prach_pkg::*;
#(
    parameter int SIZE = 32,
    localparam int CW = $clog2(SIZE),
    localparam int AW = $clog2(2 * SIZE)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [CW-1:0] wcyc_i,
    input  sample_t       wd1_i,
    input  sample_t       wd2_i,
    input  logic          re_i,
    input  logic          rbank_i,
    input  logic [CW-1:0] rj_i,
    output sample_t       rd1_o,
    output sample_t       rd2_o
);

    sample_t mem [2][2*SIZE];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wbank_i][AW'(dp1_idx(int'(wcyc_i)))] <= wd1_i;
            mem[wbank_i][AW'(dp2_idx(int'(wcyc_i)))] <= wd2_i;
        end
    end

    // Read data doubles as the block's output register, zero when not draining
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_o <= '0;
            rd2_o <= '0;
        end else begin
            rd1_o <= re_i ? mem[rbank_i][AW'(dq1_idx(int'(rj_i)))] : '0;
            rd2_o <= re_i ? mem[rbank_i][AW'(dq2_idx(SIZE, int'(rj_i)))] : '0;
        end
    end

endmodule

// File: rtl/prach_unshape_ch.sv
// prach_unshape_ch: per-channel dp (even/odd) to dq (lower/upper half) reorder
// through a ping-pong buffer; fixed latency SIZE+1 from sync_in to sync_out.
module prach_unshape_ch
    import prach_pkg::*;
#(
    parameter int SIZE = 32,
    localparam int CW = $clog2(SIZE)
)(
    input  logic    clk,
    input  logic    rst,
    input  sample_t din_dp1,
    input  sample_t din_dp2,
    input  chn_t    din_chn,
    input  logic    sync_in,
    output sample_t dout_dq1,
    output sample_t dout_dq2,
    output chn_t    dout_chn,
    output logic    sync_out
);

    wr_st_t        wr_st_q;
    rd_st_t        rd_st_q;
    logic [CW-1:0] wr_cnt_q, rd_cnt_q, wr_cyc;
    logic          wb_q, rb_q, we, wr_done, rd_go, rd_done;
    logic [1:0]    full_q, set_m, clr_m;
    chn_t          tag_q [2];

    // A sync always restarts the current bank at block cycle 0
    assign wr_cyc  = sync_in ? '0 : wr_cnt_q;
    assign we      = (wr_st_q == W_FILL) || sync_in;
    assign wr_done = (wr_st_q == W_FILL) && !sync_in && (wr_cnt_q == CW'(SIZE - 1));
    assign rd_go   = (rd_st_q == R_DRAIN) || full_q[rb_q];
    assign rd_done = rd_go && (rd_cnt_q == CW'(SIZE - 1));
    assign set_m   = wr_done ? (2'b01 << wb_q) : 2'b00;
    assign clr_m   = rd_done ? (2'b01 << rb_q) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_st_q  <= W_IDLE;
            rd_st_q  <= R_IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wb_q     <= 1'b0;
            rb_q     <= 1'b0;
            full_q   <= 2'b00;
            tag_q    <= '{default: '0};
            dout_chn <= '0;
            sync_out <= 1'b0;
        end else begin
            if (we) begin
                wr_st_q  <= W_FILL;
                wr_cnt_q <= wr_done ? '0 : wr_cyc + 1'b1;
            end
            if (sync_in)
                tag_q[wb_q] <= din_chn;
            if (wr_done)
                wb_q <= ~wb_q;
            full_q <= (full_q | set_m) & ~clr_m;
            if (rd_go) begin
                rd_st_q  <= rd_done ? R_IDLE : R_DRAIN;
                rd_cnt_q <= rd_done ? '0 : rd_cnt_q + 1'b1;
                dout_chn <= tag_q[rb_q];
            end
            if (rd_done)
                rb_q <= ~rb_q;
            sync_out <= rd_go && (rd_cnt_q == '0);
        end
    end

    prach_unshape_buf #(.SIZE(SIZE)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .wbank_i (wb_q),
        .wcyc_i  (wr_cyc),
        .wd1_i   (din_dp1),
        .wd2_i   (din_dp2),
        .re_i    (rd_go),
        .rbank_i (rb_q),
        .rj_i    (rd_cnt_q),
        .rd1_o   (dout_dq1),
        .rd2_o   (dout_dq2)
    );

endmodule

// File: tb/tb_prach_unshape_ch.sv
// tb_prach_unshape_ch: scoreboard bench for SIZE=32 and SIZE=4 instances against a block-level model.
module tb_prach_unshape_ch;

    localparam int SZ [2] = '{32, 4};

    typedef struct {
        int due;
        int dq1;
        int dq2;
        int chn;
        bit sy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dp1 [2];
    logic [15:0] dp2 [2];
    logic [7:0]  chn [2];
    logic        sy  [2];
    logic [15:0] dq1 [2];
    logic [15:0] dq2 [2];
    logic [7:0]  och [2];
    logic        so  [2];

    int   ntest = 0;
    int   nfail = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit   synced [2];
    int   cnt    [2];
    int   wbp    [2];
    int   tag    [2][2];
    int   blkbuf [2][64];
    int   lastc  [2];
    exp_t me, pe;

    always #5 clk = ~clk;

    prach_unshape_ch #(.SIZE(32)) dut0 (
        .clk(clk), .rst(rst), .din_dp1(dp1[0]), .din_dp2(dp2[0]), .din_chn(chn[0]), .sync_in(sy[0]),
        .dout_dq1(dq1[0]), .dout_dq2(dq2[0]), .dout_chn(och[0]), .sync_out(so[0])
    );

    prach_unshape_ch #(.SIZE(4)) dut1 (
        .clk(clk), .rst(rst), .din_dp1(dp1[1]), .din_dp2(dp2[1]), .din_chn(chn[1]), .sync_in(sy[1]),
        .dout_dq1(dq1[1]), .dout_dq2(dq2[1]), .dout_chn(och[1]), .sync_out(so[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: collect x[] per block in sample order; a block completes after SIZE
    // cycles, once synced blocks keep following back to back, each bank keeps its last tag.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                synced[d] = 0;
                cnt[d] = 0;
                wbp[d] = 0;
                tag[d][0] = 0;
                tag[d][1] = 0;
                if (d == 0) q0.delete(); else q1.delete();
            end else begin
                if (sy[d]) begin
                    synced[d] = 1;
                    cnt[d] = 0;
                    tag[d][wbp[d]] = int'(chn[d]);
                end
                if (synced[d]) begin
                    blkbuf[d][2*cnt[d]] = int'(dp1[d]);
                    blkbuf[d][2*cnt[d]+1] = int'(dp2[d]);
                    cnt[d]++;
                    if (cnt[d] == SZ[d]) begin
                        for (int j = 0; j < SZ[d]; j++) begin
                            pe.due = cyc + 2 + j;
                            pe.dq1 = blkbuf[d][j];
                            pe.dq2 = blkbuf[d][SZ[d]+j];
                            pe.chn = tag[d][wbp[d]];
                            pe.sy  = (j == 0);
                            if (d == 0) q0.push_back(pe); else q1.push_back(pe);
                        end
                        wbp[d] ^= 1;
                        cnt[d] = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) lastc[d] = 0;
            me = '{due: cyc, dq1: 0, dq2: 0, chn: lastc[d], sy: 1'b0};
            if (d == 0 && q0.size() > 0 && q0[0].due == cyc) me = q0.pop_front();
            if (d == 1 && q1.size() > 0 && q1[0].due == cyc) me = q1.pop_front();
            lastc[d] = me.chn;
            ntest++;
            if (so[d] !== me.sy || int'(dq1[d]) != me.dq1 || int'(dq2[d]) != me.dq2 || int'(och[d]) != me.chn
                || $isunknown({so[d], dq1[d], dq2[d], och[d]})) begin
                nfail++;
                $display("FAIL out%0d cyc=%0d: got sync=%0d dq1=%0d dq2=%0d chn=%0d, want sync=%0d dq1=%0d dq2=%0d chn=%0d",
                         d, cyc, so[d], dq1[d], dq2[d], och[d], me.sy, me.dq1, me.dq2, me.chn);
            end
        end
    end

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            sy[d]  = 1'b0;
            dp1[d] = 16'($urandom);
            dp2[d] = 16'($urandom);
            chn[d] = 8'($urandom);
        end
    endtask

    task automatic blk(input int d, input int t, input int off, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            sy[d]  = (i == 0);
            dp1[d] = 16'(off + 2 * i);
            dp2[d] = 16'(off + 2 * i + 1);
            chn[d] = (i == 0) ? 8'(t) : 8'($urandom);
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        sy[0] = 1'b0;
        sy[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            dp1[d] = '0; dp2[d] = '0; chn[d] = '0; sy[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        blk(0, 5, 0, 32);
        idle(0, 40);
        do_rst();
        blk(0, 1, 0, 32);
        blk(0, 2, 100, 32);
        blk(0, 3, 200, 32);
        idle(0, 70);
        do_rst();
        blk(0, 7, 50, 10);
        blk(0, 8, 300, 32);
        idle(0, 40);
        do_rst();
        blk(0, 9, 400, 32);
        begin
            int k = 0;
            while (!so[0] && k < 100) begin
                @(negedge clk);
                k++;
            end
            ntest++;
            if (!so[0]) begin
                nfail++;
                $display("FAIL wait_sync_out: got no sync_out within %0d cycles, want one", k);
            end
        end
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        blk(0, 10, 500, 32);
        idle(0, 40);
        do_rst();
        idle(0, 200);
        blk(1, 4, 0, 4);
        idle(1, 12);
        do_rst();
        for (int d = 0; d < 2; d++) begin
            repeat (14) begin
                int len;
                len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, SZ[d] + 3)) : SZ[d];
                blk(d, int'($urandom_range(0, 255)), int'($urandom_range(0, 60000)), len);
            end
            idle(d, 2 * SZ[d] + 3);
            do_rst();
        end
        repeat (40) @(negedge clk);
        ntest++;
        if (q0.size() + q1.size() != 0) begin
            nfail++;
            $display("FAIL pending: got %0d undelivered expectations, want 0", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/prach_unshape_ch.md
Name: prach_unshape_ch

Overview:
Per-channel inverse of the PRACH reshape stage. It takes one PRACH block carried as two parallel lanes of even/odd samples (dp1/dp2). It re-emits the same block as two parallel lanes carrying the lower and upper half-blocks (dq1/dq2). A ping-pong buffer of two banks lets continuous back-to-back blocks flow without stalls. It sits on the PRACH path wherever dp-format data must return to dq format; several instances share sync and channel tags.

Parameters:
- SIZE, 32, block length in cycles. One block is 2*SIZE samples. Must be even and >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- din_dp1  input  16  sample x[2i] on block cycle i
- din_dp2  input  16  sample x[2i+1] on block cycle i
- din_chn  input  8  channel tag, sampled on sync_in
- sync_in  input  1  high on block cycle 0 (carries x[0], x[1])
- dout_dq1  output  16  x[j] on output cycle j
- dout_dq2  output  16  x[SIZE+j] on output cycle j
- dout_chn  output  8  tag of the block being output
- sync_out  output  1  high on output cycle 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: dout_dq1, dout_dq2, dout_chn, sync_out all 0. Writer goes to IDLE, reader goes to IDLE, both banks are marked empty.
- Input stream is continuous: one dp pair every cycle, with no valid signal.
- Writer FSM, IDLE and FILL:
  - IDLE ignores data until sync_in = 1. On sync_in it goes to FILL with wr_cnt = 0 and latches din_chn into the current bank's tag.
  - In FILL, cycle i writes bank[wb][2i] = din_dp1 and bank[wb][2i+1] = din_dp2.
  - When wr_cnt = SIZE-1 the write completes: the bank is marked full, wb toggles, and wr_cnt wraps to 0. The writer stays in FILL, so the next block is expected at wr_cnt = 0.
  - sync_in with wr_cnt = 0 is the normal case.
  - sync_in with wr_cnt != 0 is a resync. The partial block is discarded, wr_cnt restarts at 0 in the same bank, the cycle's data is written as block cycle 0, and the tag is re-latched.
- Reader FSM, IDLE and DRAIN:
  - When a bank becomes full, the reader enters DRAIN on the next cycle with rd_cnt = 0.
  - On cycle j it registers dout_dq1 = bank[rb][j] and dout_dq2 = bank[rb][SIZE+j]. It also sets dout_chn = tag[rb] and sync_out = (j == 0).
  - At rd_cnt = SIZE-1 it marks the bank empty and toggles rb. If the other bank is already full, it continues directly with j = 0 of that bank, so there is no gap. Otherwise it returns to IDLE.
  - In IDLE: sync_out = 0, dout_dq1/dout_dq2 = 0, dout_chn holds its last value.
- Latency: sync_in at cycle t0 gives sync_out at cycle t0+SIZE+1. Every output sample follows the same fixed latency.
- No overflow under continuous input: the writer fills one bank in SIZE cycles while the reader drains the other in SIZE cycles. A resync never touches the bank being read.
- Simultaneous bank full and reader finishing: the reader handles it with the back-to-back rule above.
- Reset asserted mid-operation: the next cycle shows all outputs at 0 and all pending blocks are dropped. The first sync_out comes SIZE+1 cycles after the next sync_in.
- Storage: a flop array of 2 banks x 2*SIZE x 16 bits, plus 2 x 8-bit tags. Writes are 2 per cycle, reads are 2 per cycle, all registered outputs.

Decomposition:
- Shared package prach_pkg holds:
  - sample_t (16-bit)
  - chn_t (8-bit)
  - the dp/dq sample mapping constants (even/odd lane index functions)
- One natural sub-module: prach_unshape_buf. It is the two-bank flop store with write port (bank, cycle, two samples) and read port (bank, j), and has a one-cycle read latency.
- Both FSMs stay in prach_unshape_ch.
- A two-channel top mirrors the existing reshape top with 2 instances. The second instance's dout_dq2 is left unconnected.

Test Plan:
1. SIZE=32, din_chn=5. Send one block with sync_in at t0, din_dp1=2i, din_dp2=2i+1. Expect sync_out at t0+33; for j=0..31, dout_dq1=j, dout_dq2=32+j, dout_chn=5. Afterwards outputs return to 0.
2. Send three back-to-back blocks tagged 1, 2, 3 with offsets 0/100/200 added to the data. Expect sync_out every 32 cycles with no gap, tags 1/2/3 in order, and data correct per block.
3. Resync: sync_in at t0, then again at t0+10. Expect exactly one sync_out, at t0+10+33, carrying the second block. The partial block produces no output.
4. Reset pulsed during DRAIN at output cycle j=7. Expect outputs 0 and sync_out 0 from the next cycle. A new sync_in gives correct output 33 cycles later.
5. After reset with no sync_in and random dp data for 200 cycles: sync_out stays 0 and dout_dq1/dout_dq2 stay 0.
6. SIZE=4. Single block with x[k]=k. Expect latency 5, dout_dq1 = 0,1,2,3 and dout_dq2 = 4,5,6,7.
